// File: rtl/scr1_tcm_pkg.sv
// -----------------------------------------------------------------------------
// scr1_tcm_pkg
// Shared types and helpers for the dual-port TCM RAM.
//   tcm_state_e       : clear-sweep / normal-operation state of the array
//   TCM_CLR_VAL_DFLT  : default word written by the post-reset clear sweep
//   tcm_aw()          : word-address width for a given byte size
// -----------------------------------------------------------------------------
package scr1_tcm_pkg;

  typedef enum logic {
    TCM_CLR = 1'b0,
    TCM_RUN = 1'b1
  } tcm_state_e;

  localparam logic [31:0] TCM_CLR_VAL_DFLT = 32'h0000_0000;

  // Word address width: byte address bits above the 4-byte word offset.
  function automatic int tcm_aw(input int size_bytes);
    return $clog2(size_bytes) - 2;
  endfunction

endpackage

// File: rtl/scr1_tcm_rd_pipe.sv
// -----------------------------------------------------------------------------
// scr1_tcm_rd_pipe
// Optional output register stage for one read port of the TCM RAM.
//   clk, rst_n : clock, synchronous active-low reset
//   i_data     : read data from the array stage
//   i_vld      : i_data updated this cycle
//   o_data     : port read data (held between reads)
//   o_vld      : o_data updated this cycle (single-cycle pulse)
// OUT_REG=0 passes the array stage straight through; OUT_REG=1 adds one
// register, accepting a new read every cycle.
// -----------------------------------------------------------------------------
module scr1_tcm_rd_pipe
  import scr1_tcm_pkg::*;
#(
  parameter int SCR1_WIDTH = 32,
  parameter int OUT_REG    = 0
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SCR1_WIDTH-1:0] i_data,
  input  logic                  i_vld,
  output logic [SCR1_WIDTH-1:0] o_data,
  output logic                  o_vld
);

  generate
    if (OUT_REG != 0) begin : g_reg
      logic [SCR1_WIDTH-1:0] r_data;
      logic                  r_vld;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_data <= '0;
          r_vld  <= 1'b0;
        end else begin
          r_vld <= i_vld;
          // Capture only on a real read so the output holds otherwise.
          if (i_vld) r_data <= i_data;
        end
      end

      assign o_data = r_data;
      assign o_vld  = r_vld;
    end else begin : g_bypass
      // Clock and reset have no load in the bypass configuration.
      logic w_unused;
      assign w_unused = clk ^ rst_n;
      assign o_data   = i_data;
      assign o_vld    = i_vld;
    end
  endgenerate

endmodule

// File: rtl/scr1_tcm_dp_ram.sv
// -----------------------------------------------------------------------------
// scr1_tcm_dp_ram
// Dual-port synchronous TCM RAM with byte enables. Port A is read-only
// (instruction side), port B is read/write (data side).
//   clk, rst_n          : clock, synchronous active-low reset
//   rdy                 : array usable (low during the post-reset clear sweep)
//   rena, addra         : port A read request / word address
//   qa, qa_vld          : port A read data / update strobe
//   renb, wenb, webb    : port B read request, write request, byte enables
//   addrb, datab        : port B word address / write data
//   qb, qb_vld          : port B read data / update strobe
// Read latency is 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1). With WR_FWD=1
// a port-B write merges byte-wise into a same-cycle same-address port-A read.
// -----------------------------------------------------------------------------
module scr1_tcm_dp_ram
  import scr1_tcm_pkg::*;
#(
  parameter  int                    SCR1_WIDTH  = 32,
  parameter  int                    SCR1_SIZE   = 65536,
  parameter  int                    SCR1_NBYTES = SCR1_WIDTH / 8,
  parameter  int                    OUT_REG     = 0,
  parameter  int                    WR_FWD      = 1,
  parameter  int                    CLR_ON_RST  = 1,
  parameter  logic [SCR1_WIDTH-1:0] CLR_VAL     = SCR1_WIDTH'(TCM_CLR_VAL_DFLT),
  localparam int                    DEPTH       = SCR1_SIZE / SCR1_NBYTES,
  localparam int                    AW          = tcm_aw(SCR1_SIZE)
)(
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   rdy,
  input  logic                   rena,
  input  logic [AW-1:0]          addra,
  output logic [SCR1_WIDTH-1:0]  qa,
  output logic                   qa_vld,
  input  logic                   renb,
  input  logic                   wenb,
  input  logic [SCR1_NBYTES-1:0] webb,
  input  logic [AW-1:0]          addrb,
  input  logic [SCR1_WIDTH-1:0]  datab,
  output logic [SCR1_WIDTH-1:0]  qb,
  output logic                   qb_vld
);

  localparam logic [AW-1:0] CNT_LAST = AW'(DEPTH - 1);
  localparam tcm_state_e    ST_RST   = (CLR_ON_RST != 0) ? TCM_CLR : TCM_RUN;

  tcm_state_e              r_state, w_state_nxt;
  logic [AW-1:0]           r_cnt, w_cnt_nxt;
  logic                    w_run;

  logic [SCR1_WIDTH-1:0]   r_mem [DEPTH];

  logic [SCR1_NBYTES-1:0]  w_wbe;
  logic [AW-1:0]           w_waddr;
  logic [SCR1_WIDTH-1:0]   w_wdata;

  logic                    w_rd_a, w_rd_b;
  logic [SCR1_NBYTES-1:0]  w_fwd_be;
  logic [SCR1_WIDTH-1:0]   r_a_mem, r_a_fwd_data, r_b_mem;
  logic [SCR1_NBYTES-1:0]  r_a_fwd_be;
  logic                    r_a_vld, r_b_vld;
  logic [SCR1_WIDTH-1:0]   w_qa_s1;

  // ---- clear-sweep FSM ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_RST;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      TCM_CLR: begin
        w_cnt_nxt = r_cnt + AW'(1);
        if (r_cnt == CNT_LAST) w_state_nxt = TCM_RUN;
      end
      default: ;
    endcase
  end

  assign w_run = (r_state == TCM_RUN);
  assign rdy   = w_run;

  // ---- array write port (sweep or port B) ----
  always_comb begin
    w_wbe   = '0;
    w_waddr = addrb;
    w_wdata = datab;
    // No array writes while reset is held.
    if (rst_n) begin
      if (!w_run) begin
        w_wbe   = '1;
        w_waddr = r_cnt;
        w_wdata = CLR_VAL;
      end else if (wenb) begin
        w_wbe = webb;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < SCR1_NBYTES; i++) begin
      if (w_wbe[i]) r_mem[w_waddr][i*8 +: 8] <= w_wdata[i*8 +: 8];
    end
  end

  // ---- array read stage ----
  assign w_rd_a = w_run & rena;
  assign w_rd_b = w_run & renb;

  // Forwarding info is registered beside the raw array word so the array
  // read stays a plain read-first block RAM; the merge happens afterwards.
  always_comb begin
    w_fwd_be = '0;
    if ((WR_FWD != 0) && wenb && (addra == addrb)) w_fwd_be = webb;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a_mem      <= '0;
      r_a_fwd_be   <= '0;
      r_a_fwd_data <= '0;
      r_a_vld      <= 1'b0;
      r_b_mem      <= '0;
      r_b_vld      <= 1'b0;
    end else begin
      r_a_vld <= w_rd_a;
      r_b_vld <= w_rd_b;
      if (w_rd_a) begin
        r_a_mem      <= r_mem[addra];
        r_a_fwd_be   <= w_fwd_be;
        r_a_fwd_data <= datab;
      end
      if (w_rd_b) r_b_mem <= r_mem[addrb];
    end
  end

  always_comb begin
    w_qa_s1 = r_a_mem;
    for (int i = 0; i < SCR1_NBYTES; i++) begin
      if (r_a_fwd_be[i]) w_qa_s1[i*8 +: 8] = r_a_fwd_data[i*8 +: 8];
    end
  end

  // ---- optional output stage ----
  scr1_tcm_rd_pipe #(
    .SCR1_WIDTH (SCR1_WIDTH),
    .OUT_REG    (OUT_REG)
  ) u_pipe_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_data (w_qa_s1),
    .i_vld  (r_a_vld),
    .o_data (qa),
    .o_vld  (qa_vld)
  );

  scr1_tcm_rd_pipe #(
    .SCR1_WIDTH (SCR1_WIDTH),
    .OUT_REG    (OUT_REG)
  ) u_pipe_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_data (r_b_mem),
    .i_vld  (r_b_vld),
    .o_data (qb),
    .o_vld  (qb_vld)
  );

endmodule

// File: tb/tb_scr1_tcm_dp_ram.sv
// Two instances share one stimulus stream:
//   dut0: OUT_REG=0, WR_FWD=1   (channels 0 = port A, 1 = port B)
//   dut1: OUT_REG=1, WR_FWD=0   (channels 2 = port A, 3 = port B)
// The driver keeps a word-array model and pushes expected read results
// (with the cycle they must appear) into per-channel queues; the monitor
// pops and compares whenever a vld strobe is seen.
module tb_scr1_tcm_dp_ram;

  localparam logic [31:0] CLR_V = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rena, renb, wenb;
  logic [3:0]  addra, addrb, webb;
  logic [31:0] datab;

  logic        rdy0, qa_vld0, qb_vld0, rdy1, qa_vld1, qb_vld1;
  logic [31:0] qa0, qb0, qa1, qb1;

  scr1_tcm_dp_ram #(
    .SCR1_WIDTH(32), .SCR1_SIZE(64), .OUT_REG(0), .WR_FWD(1),
    .CLR_ON_RST(1), .CLR_VAL(CLR_V)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .rdy(rdy0),
    .rena(rena), .addra(addra), .qa(qa0), .qa_vld(qa_vld0),
    .renb(renb), .wenb(wenb), .webb(webb), .addrb(addrb), .datab(datab),
    .qb(qb0), .qb_vld(qb_vld0)
  );

  scr1_tcm_dp_ram #(
    .SCR1_WIDTH(32), .SCR1_SIZE(64), .OUT_REG(1), .WR_FWD(0),
    .CLR_ON_RST(1), .CLR_VAL(CLR_V)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .rdy(rdy1),
    .rena(rena), .addra(addra), .qa(qa1), .qa_vld(qa_vld1),
    .renb(renb), .wenb(wenb), .webb(webb), .addrb(addrb), .datab(datab),
    .qb(qb1), .qb_vld(qb_vld1)
  );

  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] d;
  } exp_t;

  exp_t        sbq [4][$];
  logic [31:0] last [4];

  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  // Reference model state
  logic [31:0] mmem [16];
  bit          m_clr;
  int          m_cnt;
  bit          m_rdy;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] merge(input logic [31:0] old_w,
                                        input logic [31:0] new_w,
                                        input logic [3:0]  be);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    return r;
  endfunction

  task automatic push(input int ch, input int unsigned c, input logic [31:0] d);
    exp_t e;
    e.cyc = c;
    e.d   = d;
    sbq[ch].push_back(e);
  endtask

  // One clock of stimulus, applied at the negedge before the edge it acts on.
  task automatic step(input bit rn, input bit ra, input logic [3:0] aa,
                      input bit rb, input bit wb, input logic [3:0] be,
                      input logic [3:0] ab, input logic [31:0] db);
    int unsigned e;
    @(negedge clk);
    rst_n = rn; rena = ra; addra = aa; renb = rb; wenb = wb;
    webb = be; addrb = ab; datab = db;
    e = cyc + 1;
    if (!rn) begin
      m_clr = 1'b1;
      m_cnt = 0;
      for (int ch = 0; ch < 4; ch++) sbq[ch].delete();
    end else if (m_clr) begin
      mmem[m_cnt] = CLR_V;
      m_cnt++;
      if (m_cnt == 16) m_clr = 1'b0;
    end else begin
      if (ra) begin
        push(0, e, (wb && aa == ab) ? merge(mmem[aa], db, be) : mmem[aa]);
        push(2, e + 1, mmem[aa]);
      end
      if (rb) begin
        push(1, e, mmem[ab]);
        push(3, e + 1, mmem[ab]);
      end
      if (wb) mmem[ab] = merge(mmem[ab], db, be);
    end
    m_rdy = !m_clr;
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 32'd0);
  endtask

  task automatic rst_cyc();
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 32'd0);
  endtask

  task automatic junk();
    logic [3:0] aa;
    aa = 4'($urandom);
    step(1'b1, 1'($urandom), aa, 1'($urandom), 1'($urandom), 4'($urandom),
         (($urandom % 4) == 0) ? aa : 4'($urandom), $urandom);
  endtask

  task automatic mon(input int ch, input logic v, input logic [31:0] d);
    exp_t e;
    vectors++;
    if (!rst_n) begin
      if (v !== 1'b0 || d !== 32'd0) begin
        miscompares++;
        $display("FAIL reset_q ch%0d cyc%0d: got vld=%b q=%h, want vld=0 q=00000000",
                 ch, cyc, v, d);
      end
      last[ch] = 32'd0;
    end else if (v === 1'b1) begin
      if (sbq[ch].size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_vld ch%0d cyc%0d: got q=%h, want no vld", ch, cyc, d);
      end else begin
        e = sbq[ch].pop_front();
        if (e.cyc != 32'(cyc) || d !== e.d) begin
          miscompares++;
          $display("FAIL read ch%0d: got q=%h at cyc%0d, want q=%h at cyc%0d",
                   ch, d, cyc, e.d, e.cyc);
        end
      end
      last[ch] = d;
    end else begin
      if (v !== 1'b0 || d !== last[ch]) begin
        miscompares++;
        $display("FAIL hold ch%0d cyc%0d: got vld=%b q=%h, want vld=0 q=%h",
                 ch, cyc, v, d, last[ch]);
      end
      if (sbq[ch].size() > 0 && sbq[ch][0].cyc < 32'(cyc)) begin
        e = sbq[ch].pop_front();
        miscompares++;
        $display("FAIL missing_vld ch%0d cyc%0d: got no vld, want q=%h at cyc%0d",
                 ch, cyc, e.d, e.cyc);
      end
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    mon(0, qa_vld0, qa0);
    mon(1, qb_vld0, qb0);
    mon(2, qa_vld1, qa1);
    mon(3, qb_vld1, qb1);
    vectors += 2;
    if (rdy0 !== m_rdy) begin
      miscompares++;
      $display("FAIL rdy dut0 cyc%0d: got %b, want %b", cyc, rdy0, m_rdy);
    end
    if (rdy1 !== m_rdy) begin
      miscompares++;
      $display("FAIL rdy dut1 cyc%0d: got %b, want %b", cyc, rdy1, m_rdy);
    end
  end

  initial begin
    rst_n = 1'b0; rena = 1'b0; renb = 1'b0; wenb = 1'b0;
    addra = '0; addrb = '0; webb = '0; datab = '0;
    m_clr = 1'b1; m_cnt = 0; m_rdy = 1'b0;
    for (int i = 0; i < 16; i++) mmem[i] = 32'd0;
    for (int ch = 0; ch < 4; ch++) last[ch] = 32'd0;

    repeat (3) rst_cyc();
    // Sweep interrupted at cycle 7, then a full sweep with ignored requests
    repeat (7) junk();
    repeat (2) rst_cyc();
    repeat (16) junk();

    // Whole array holds the clear value
    for (int i = 0; i < 16; i++)
      step(1'b1, 1'b1, 4'(i), 1'b1, 1'b0, 4'd0, 4'(15 - i), 32'd0);
    repeat (2) idle();

    // Byte-enable write merge at addr 3
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'hF, 4'd3, 32'h1122_3344);
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'b0101, 4'd3, 32'hAABB_CCDD);
    step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 4'd3, 32'd0);
    idle();

    // Same-cycle port A read / port B write at addr 5
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'hF, 4'd5, 32'h0);
    step(1'b1, 1'b1, 4'd5, 1'b0, 1'b1, 4'b1000, 4'd5, 32'hFFFF_FFFF);
    step(1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 4'd0, 4'd0, 32'd0);
    idle();

    // Read-first on port B at addr 9
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'hF, 4'd9, 32'h5);
    step(1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'hF, 4'd9, 32'h7);
    step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 4'd9, 32'd0);
    idle();

    // Back-to-back port A reads
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b1, 4'(i), 1'b0, 1'b0, 4'd0, 4'd0, 32'd0);
    repeat (3) idle();

    repeat (500) junk();
    repeat (2) idle();

    // Reset in the middle of operation restarts the sweep
    repeat (2) rst_cyc();
    repeat (16) junk();
    for (int i = 0; i < 16; i++)
      step(1'b1, 1'b1, 4'(i), 1'b1, 1'b0, 4'd0, 4'(i), 32'd0);
    repeat (60) junk();

    repeat (4) idle();
    @(posedge clk);
    #2;
    for (int ch = 0; ch < 4; ch++) begin
      vectors++;
      if (sbq[ch].size() != 0) begin
        miscompares++;
        $display("FAIL leftover ch%0d: got %0d pending reads, want 0", ch, sbq[ch].size());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
